// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and types for the stream_mux selector
package stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int XFER_CNT_W = 16;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/stream_mux_rr_pick.sv
// rtl/stream_mux_rr_pick.sv - rr_pick: combinational rotating-priority search
// Finds the first set valid bit starting at ptr+1 and wrapping modulo NCH.
module rr_pick #(
   parameter int NCH = 4,
   parameter int SW  = 2
) (
   input  logic [NCH-1:0] valid,
   input  logic [SW-1:0]  ptr,
   output logic [SW-1:0]  grant,
   output logic           grant_valid
);

   int          idx;
   logic [SW-1:0] cand;

   // Walk from the farthest candidate back to the nearest so the nearest match wins.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      cand        = '0;
      for (int k = NCH; k >= 1; k--) begin
         idx  = (int'(ptr) + k) % NCH;
         cand = SW'(idx);
         if (valid[cand]) begin
            grant       = cand;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-channel valid/ready stream selector with one registered output stage
// Fixed-select or round-robin; define STREAM_MUX_XFER_CNT_EN to add the saturating xfer_cnt output.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter  int DW  = 4,
   parameter  int NCH = 4,
   localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*DW-1:0] in_data,
   input  logic [NCH-1:0]    in_valid,
   output logic [NCH-1:0]    in_ready,
   input  logic              mode,
   input  logic [SW-1:0]     sel,
   output logic [DW-1:0]     out_data,
   output logic [SW-1:0]     out_chan,
   output logic              out_valid,
   input  logic              out_ready
`ifdef STREAM_MUX_XFER_CNT_EN
   ,
   output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

   out_state_t    state;
   logic [SW-1:0] ptr;
   logic [SW-1:0] rr_grant;
   logic          rr_valid;
   logic          fix_valid;
   logic [SW-1:0] grant;
   logic          grant_valid;
   logic          load_ok;
   logic          xfer;
   logic [DW-1:0] sel_data;

   rr_pick #(
      .NCH (NCH),
      .SW  (SW)
   ) u_rr_pick (
      .valid       (in_valid),
      .ptr         (ptr),
      .grant       (rr_grant),
      .grant_valid (rr_valid)
   );

   // sel can exceed NCH-1 when NCH is not a power of two; such a select never grants.
   always_comb begin
      fix_valid = 1'b0;
      if (int'(sel) < NCH) begin
         fix_valid = in_valid[sel];
      end
   end

   always_comb begin
      grant       = sel;
      grant_valid = fix_valid;
      if (mode == MODE_RR) begin
         grant       = rr_grant;
         grant_valid = rr_valid;
      end
   end

   assign out_valid = (state == OUT_FULL);
   assign load_ok   = !out_valid || out_ready;
   assign xfer      = load_ok && grant_valid && rst_n;

   always_comb begin
      in_ready = '0;
      if (xfer) begin
         in_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant == SW'(i)) begin
            sel_data = in_data[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= OUT_EMPTY;
         out_data <= '0;
         out_chan <= '0;
         ptr      <= SW'(NCH - 1);
      end else begin
         case (state)
            OUT_EMPTY: begin
               if (xfer) begin
                  state    <= OUT_FULL;
                  out_data <= sel_data;
                  out_chan <= grant;
                  if (mode == MODE_RR) begin
                     ptr <= grant;
                  end
               end
            end
            OUT_FULL: begin
               // A load while draining replaces the word in place, so there is no bubble.
               if (xfer) begin
                  out_data <= sel_data;
                  out_chan <= grant;
                  if (mode == MODE_RR) begin
                     ptr <= grant;
                  end
               end else if (out_ready) begin
                  state <= OUT_EMPTY;
               end
            end
            default: state <= OUT_EMPTY;
         endcase
      end
   end

`ifdef STREAM_MUX_XFER_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (out_valid && out_ready && (xfer_cnt != {XFER_CNT_W{1'b1}})) begin
         xfer_cnt <= xfer_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - randomized, model-checked bench for stream_mux
module tb_stream_mux;
   import stream_mux_pkg::*;

   localparam int DW  = 4;
   localparam int NCH = 4;
   localparam int SW  = 2;
   localparam int N3  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic              mode;
   logic [SW-1:0]     sel;
   logic [DW-1:0]     out_data;
   logic [SW-1:0]     out_chan;
   logic              out_valid;
   logic              out_ready;

   logic [N3*DW-1:0]  in_data3;
   logic [N3-1:0]     in_valid3;
   logic [N3-1:0]     in_ready3;
   logic [SW-1:0]     sel3;
   logic [DW-1:0]     out_data3;
   logic [SW-1:0]     out_chan3;
   logic              out_valid3;
`ifdef STREAM_MUX_XFER_CNT_EN
   logic [15:0]       xfer_cnt;
   logic [15:0]       xfer_cnt3;
`endif

   stream_mux #(.DW(DW), .NCH(NCH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   stream_mux #(.DW(DW), .NCH(N3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .mode      (MODE_FIXED),
      .sel       (sel3),
      .out_data  (out_data3),
      .out_chan  (out_chan3),
      .out_valid (out_valid3),
      .out_ready (out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
      ,
      .xfer_cnt  (xfer_cnt3)
`endif
   );

   int total = 0;
   int bad   = 0;

   logic          m_valid;
   logic [DW-1:0] m_data;
   int            m_chan;
   int            m_ptr;
   int            m_cnt;

   int rr_all [5] = '{0, 1, 2, 3, 0};
   int rr_alt [4] = '{1, 3, 1, 3};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = NCH - 1;
      m_cnt   = 0;
   endtask

   // Channel chosen this cycle by the selection rules, or -1 for none.
   function automatic int model_grant(input logic md, input logic [SW-1:0] s,
                                      input logic [NCH-1:0] v, input int p);
      if (md == MODE_FIXED) begin
         if (int'(s) < NCH && ((v >> s) & 1) == 1) return int'(s);
         return -1;
      end
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (p + k) % NCH;
         if (((v >> c) & 1) == 1) return c;
      end
      return -1;
   endfunction

   // Called at posedge+1 (or +2) with inputs already driven; returns at the next posedge+1.
   task automatic step();
      int             g;
      logic           lok;
      logic [NCH-1:0] exp_rdy;
      #2;
      lok     = !m_valid || out_ready;
      g       = model_grant(mode, sel, in_valid, m_ptr);
      exp_rdy = (lok && g >= 0) ? (NCH'(1) << g) : '0;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk("out_data", 32'(out_data), 32'(m_data));
         chk("out_chan", 32'(out_chan), 32'(m_chan));
      end
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef STREAM_MUX_XFER_CNT_EN
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
      if (m_valid && out_ready && m_cnt < 65535) m_cnt++;
`endif
      if (lok && g >= 0) begin
         m_valid = 1'b1;
         m_data  = DW'(in_data >> (g * DW));
         m_chan  = g;
         if (mode == MODE_RR) m_ptr = g;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = '0;
      mode      = MODE_RR;
      sel       = '0;
      out_ready = 1'b0;
      in_data3  = '0;
      in_valid3 = '0;
      sel3      = '0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      in_valid = 4'hF;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_chan", 32'(out_chan), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      sel3      = 2'd3;
      in_valid3 = 3'b111;
      in_data3  = 12'h321;
      mode      = MODE_FIXED;
      sel       = 2'd2;
      in_valid  = 4'b0100;
      in_data   = 16'h0A00;
      out_ready = 1'b1;
      #1;
      chk("fix_in_ready", 32'(in_ready), 32'b0100);
      chk("oor_in_ready", 32'(in_ready3), 32'd0);
      step();
      chk("fix_out_data", 32'(out_data), 32'hA);
      chk("fix_out_chan", 32'(out_chan), 32'd2);
      chk("fix_out_valid", 32'(out_valid), 32'd1);
      repeat (2) begin
         in_valid = '0;
         step();
         chk("oor_in_ready", 32'(in_ready3), 32'd0);
         chk("oor_out_valid", 32'(out_valid3), 32'd0);
      end
      in_valid3 = '0;

      mode     = MODE_RR;
      in_valid = 4'hF;
      in_data  = 16'h4321;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_all_chan", 32'(out_chan), 32'(rr_all[i]));
      end
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_alt_chan", 32'(out_chan), 32'(rr_alt[i]));
      end

      mode     = MODE_FIXED;
      sel      = 2'd1;
      in_valid = 4'b0010;
      in_data  = 16'h0050;
      step();
      chk("bp_load_data", 32'(out_data), 32'h5);
      out_ready = 1'b0;
      in_data   = 16'h0070;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         step();
         chk("bp_hold_data", 32'(out_data), 32'h5);
         chk("bp_hold_chan", 32'(out_chan), 32'd1);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'b0010);
      step();
      chk("bp_next_data", 32'(out_data), 32'h7);
      chk("bp_next_valid", 32'(out_valid), 32'd1);

      for (int i = 0; i < 600; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = NCH'($urandom);
         in_data   = (NCH*DW)'($urandom);
         sel       = SW'($urandom);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         step();
      end

      mode      = MODE_RR;
      in_valid  = 4'hF;
      out_ready = 1'b0;
      step();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      chk("post_rst_chan", 32'(out_chan), 32'd0);

`ifdef STREAM_MUX_XFER_CNT_EN
      repeat (5) step();
      chk("cnt_five", 32'(xfer_cnt), 32'd5);
      repeat (65540) step();
      chk("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
